// File: rtl/input_tokenizer_if.sv
// input_tokenizer_pkg / input_tokenizer_if: keypad command codes, token kinds
// and the command-in / token-out bundle of the tokenizer.
package input_tokenizer_pkg;
    localparam int IC_W = 5;
    typedef logic [IC_W-1:0] ic_t;
    localparam ic_t IC_NONE = 5'd0;
    localparam ic_t IC_D0   = 5'd1;
    localparam ic_t IC_D9   = 5'd10;
    localparam ic_t IC_OPAD = 5'd11;
    localparam ic_t IC_CTOK = 5'd17;
    localparam ic_t IC_CLBK = 5'd18;
    localparam ic_t IC_CLCL = 5'd19;
    typedef logic [3:0] kind_t;
    localparam kind_t TK_NUM  = 4'd0;
    localparam kind_t TK_BACK = 4'd8;
    localparam kind_t TK_CLR  = 4'd9;
endpackage

interface input_tokenizer_if #(
    parameter int DW = 16
);
    import input_tokenizer_pkg::*;
    ic_t           cmd_i;
    logic          tok_ready_i;
    logic          tok_valid_o;
    kind_t         tok_kind_o;
    logic [DW-1:0] tok_value_o;
    logic [DW-1:0] entry_value_o;
    logic          entry_active_o;
    logic          ovf_o;
    logic          drop_o;
    modport master (
        output cmd_i, tok_ready_i,
        input  tok_valid_o, tok_kind_o, tok_value_o, entry_value_o, entry_active_o, ovf_o, drop_o
    );
    modport slave (
        input  cmd_i, tok_ready_i,
        output tok_valid_o, tok_kind_o, tok_value_o, entry_value_o, entry_active_o, ovf_o, drop_o
    );
endinterface

// File: rtl/input_tokenizer.sv
// input_tokenizer: accumulates keypad digits into a saturating operand and
// emits NUM/operator/control tokens through a 4-entry show-ahead FIFO.
module input_tokenizer
    import input_tokenizer_pkg::*;
#(
    parameter int DW = 16
) (
    input logic              clk_i,
    input logic              rst_i,
    input_tokenizer_if.slave bus
);
    typedef enum logic {IDLE, ENTRY} state_e;
    state_e        state_q, state_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [3:0]    ndig_q, ndig_d;
    logic          ovf_q, ovf_d, drop_q, drop_d;
    kind_t         kind_q [4];
    logic [DW-1:0] val_q [4];
    logic [1:0]    wp_q, rp_q, wa, need, np;
    logic [2:0]    cnt_q;
    logic          is_dig, is_op, is_bk, is_clr, entry, pop, space_ok;
    logic [3:0]    d;
    kind_t         op_kind, k0;
    logic [DW-1:0] v0;
    logic [DW+3:0] nxt;

    assign entry    = state_q == ENTRY;
    assign is_dig   = bus.cmd_i >= IC_D0 && bus.cmd_i <= IC_D9;
    assign is_op    = bus.cmd_i >= IC_OPAD && bus.cmd_i <= IC_CTOK;
    assign is_bk    = bus.cmd_i == IC_CLBK;
    assign is_clr   = bus.cmd_i == IC_CLCL;
    assign d        = 4'(bus.cmd_i - IC_D0);
    assign op_kind  = 4'(bus.cmd_i - IC_OPAD + ic_t'(1));
    assign nxt      = (DW+4)'(acc_q) * (DW+4)'(10) + (DW+4)'(d);
    assign need     = is_op ? (entry ? 2'd2 : 2'd1) : {1'b0, is_bk && !entry};
    // A same-cycle pop does not free space for this cycle's push.
    assign space_ok = 3'd4 - cnt_q >= {1'b0, need};
    assign pop      = cnt_q != 3'd0 && bus.tok_ready_i;
    assign wa       = is_clr ? 2'd0 : wp_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ndig_d  = ndig_q;
        ovf_d   = 1'b0;
        drop_d  = 1'b0;
        np      = 2'd0;
        k0      = op_kind;
        v0      = '0;
        if (is_clr) begin
            np      = 2'd1;
            k0      = TK_CLR;
            state_d = IDLE;
            acc_d   = '0;
            ndig_d  = '0;
        end else if (!space_ok) begin
            drop_d = 1'b1;
        end else if (is_dig) begin
            if (!entry) begin
                acc_d   = DW'(d);
                ndig_d  = 4'd1;
                state_d = ENTRY;
            end else if (nxt[DW+3:DW] != 4'd0 || ndig_q == 4'd15) begin
                ovf_d = 1'b1;
            end else begin
                acc_d  = nxt[DW-1:0];
                ndig_d = ndig_q + 4'd1;
            end
        end else if (is_op) begin
            np      = entry ? 2'd2 : 2'd1;
            k0      = entry ? TK_NUM : op_kind;
            v0      = entry ? acc_q : '0;
            state_d = IDLE;
            acc_d   = '0;
            ndig_d  = '0;
        end else if (is_bk) begin
            np      = entry ? 2'd0 : 2'd1;
            k0      = TK_BACK;
            acc_d   = acc_q / DW'(10);
            ndig_d  = entry ? ndig_q - 4'd1 : ndig_q;
            state_d = entry && ndig_q == 4'd1 ? IDLE : state_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ndig_q  <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ndig_q  <= ndig_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            wp_q    <= is_clr ? 2'd1 : wp_q + np;
            rp_q    <= is_clr ? 2'd0 : rp_q + 2'(pop);
            cnt_q   <= is_clr ? 3'd1 : cnt_q + 3'(np) - 3'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && np != 2'd0) begin
            kind_q[wa] <= k0;
            val_q[wa]  <= v0;
        end
        if (!rst_i && np == 2'd2) begin
            kind_q[wa+2'd1] <= op_kind;
            val_q[wa+2'd1]  <= '0;
        end
    end

    assign bus.tok_valid_o    = cnt_q != 3'd0;
    assign bus.tok_kind_o     = cnt_q != 3'd0 ? kind_q[rp_q] : TK_NUM;
    assign bus.tok_value_o    = cnt_q != 3'd0 ? val_q[rp_q] : '0;
    assign bus.entry_value_o  = acc_q;
    assign bus.entry_active_o = entry;
    assign bus.ovf_o          = ovf_q;
    assign bus.drop_o         = drop_q;
endmodule

// File: tb/tb_input_tokenizer.sv
// tb_input_tokenizer: directed plan plus random commands against a queue-based
// reference model of the tokenizer.
module tb_input_tokenizer;
    import input_tokenizer_pkg::*;
    typedef struct {int k; int v;} tok_t;
    localparam int MAXV = 65535;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    tok_t q[$];
    int   acc = 0;
    int   nd = 0;
    bit   ent = 0;
    bit   m_ovf = 0;
    bit   m_drop = 0;

    input_tokenizer_if #(.DW(16)) bus();
    input_tokenizer #(.DW(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    task automatic check_all();
        int hk = 0;
        int hv = 0;
        if (q.size() != 0) begin
            hk = q[0].k;
            hv = q[0].v;
        end
        chk("tok_valid", 32'(bus.tok_valid_o), 32'(q.size() != 0));
        chk("tok_kind", 32'(bus.tok_kind_o), hk);
        chk("tok_value", 32'(bus.tok_value_o), hv);
        chk("entry_value", 32'(bus.entry_value_o), acc);
        chk("entry_active", 32'(bus.entry_active_o), 32'(ent));
        chk("ovf", 32'(bus.ovf_o), 32'(m_ovf));
        chk("drop", 32'(bus.drop_o), 32'(m_drop));
    endtask

    task automatic model(input int c, input bit rdy);
        bit pop = q.size() != 0 && rdy;
        bit isdig = c >= 1 && c <= 10;
        bit isop = c >= 11 && c <= 17;
        bit isbk = c == 18;
        int need;
        m_ovf = 0;
        m_drop = 0;
        if (c == 19) begin
            q.delete();
            q.push_back('{9, 0});
            acc = 0; nd = 0; ent = 0;
            return;
        end
        need = isop ? (ent ? 2 : 1) : (isbk && !ent) ? 1 : 0;
        if (4 - q.size() < need) begin
            m_drop = 1;
            if (pop) void'(q.pop_front());
            return;
        end
        if (pop) void'(q.pop_front());
        if (isdig) begin
            if (!ent) begin
                acc = c - 1; nd = 1; ent = 1;
            end else if (acc * 10 + (c - 1) > MAXV || nd == 15) begin
                m_ovf = 1;
            end else begin
                acc = acc * 10 + (c - 1); nd++;
            end
        end else if (isop) begin
            if (ent) q.push_back('{0, acc});
            q.push_back('{c - 10, 0});
            acc = 0; nd = 0; ent = 0;
        end else if (isbk) begin
            if (ent) begin
                acc = acc / 10; nd--;
                if (nd == 0) ent = 0;
            end else q.push_back('{8, 0});
        end
    endtask

    task automatic step(input int c, input bit rdy);
        bus.cmd_i = ic_t'(c);
        bus.tok_ready_i = rdy;
        @(posedge clk);
        model(c, rdy);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.cmd_i = ic_t'($urandom_range(1, 19));
        bus.tok_ready_i = 1'b0;
        @(posedge clk);
        q.delete();
        acc = 0; nd = 0; ent = 0; m_ovf = 0; m_drop = 0;
        @(negedge clk);
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        bus.cmd_i = IC_NONE;
        bus.tok_ready_i = 1'b0;
        do_reset();
        // 1,2,3 then OPAD
        step(2, 1); chk("d1", 32'(bus.entry_value_o), 1);
        step(3, 1); chk("d12", 32'(bus.entry_value_o), 12);
        step(4, 1); chk("d123", 32'(bus.entry_value_o), 123);
        step(11, 1); chk("num123", 32'(bus.tok_value_o), 123);
        step(0, 1); chk("add", 32'(bus.tok_kind_o), 1);
        step(0, 1);
        // saturation at 65535
        step(7, 1); step(6, 1); step(6, 1); step(4, 1); step(6, 1);
        chk("acc_max", 32'(bus.entry_value_o), 65535);
        step(1, 1); chk("ovf_sat", 32'(bus.ovf_o), 1);
        step(17, 1); chk("num_max", 32'(bus.tok_value_o), 65535);
        step(0, 1); chk("ok", 32'(bus.tok_kind_o), 7);
        step(0, 1);
        // backspace
        step(5, 1); step(6, 1); step(18, 1); chk("bk4", 32'(bus.entry_value_o), 4);
        step(18, 1); step(18, 1); chk("back", 32'(bus.tok_kind_o), 8);
        step(0, 1);
        // full FIFO
        step(15, 0); step(13, 0); step(16, 0); step(15, 0);
        step(8, 0); chk("d7_full", 32'(bus.entry_value_o), 7);
        step(12, 0); chk("drop_full", 32'(bus.drop_o), 1);
        step(0, 1); chk("mul", 32'(bus.tok_kind_o), 3);
        step(0, 1); step(0, 1); step(0, 1); step(0, 1);
        // 3 held, acc=9, CTOK dropped, CLCL flushes
        step(19, 1); step(0, 1);
        step(15, 0); step(15, 0); step(15, 0); step(10, 0);
        step(17, 0); chk("drop_ctok", 32'(bus.drop_o), 1);
        chk("acc9", 32'(bus.entry_value_o), 9);
        step(19, 1); chk("clr", 32'(bus.tok_kind_o), 9);
        step(0, 0); step(0, 1);
        // reset during ENTRY with 2 queued
        step(15, 0); step(15, 0); step(4, 0);
        do_reset(); chk("rst_valid", 32'(bus.tok_valid_o), 0);
        // digit-count limit with leading zeros
        for (int i = 0; i < 15; i++) step(1, 1);
        step(1, 1); chk("ovf_ndig", 32'(bus.ovf_o), 1);
        step(19, 1); step(0, 1);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int r = $urandom_range(0, 99);
            int c = r < 25 ? 0 : r < 60 ? $urandom_range(1, 10) : r < 85 ? $urandom_range(11, 17) : r < 94 ? 18 : 19;
            if ($urandom_range(0, 299) == 0) do_reset();
            else step(c, $urandom_range(0, 9) < 6);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
